inst_fetch_unit: RTL

Downstream neighbour of the byte-wide instruction memory. It drives the byte read address and assembles four consecutive bytes (little-endian) into a 32-bit RISC-V instruction word. It presents the word with its PC to decode over a valid/ready handshake. It also accepts a redirect (branch/jump target) that aborts the current fetch.

---
 rtl/inst_fetch_unit_if.sv | 36 +++
 rtl/inst_fetch_unit.sv | 106 ++++++++++
 2 files changed

// File: rtl/inst_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit_if
// Bundles the signals around the instruction fetch unit.
//   fetch_en        : permission to start a new instruction fetch
//   mem_en/mem_addr : byte read request to instruction memory
//   mem_rdata       : byte returned combinationally for mem_addr
//   inst_valid/inst_ready/inst_data/inst_pc : instruction handshake to decode
//   redirect_valid/redirect_pc              : branch/jump target from the core
// Modports:
//   master : the fetch unit itself
//   slave  : the environment (memory, decode, redirect source)
// ---------------------------------------------------------------------------
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 10
) ();
  logic              fetch_en;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    input  fetch_en, mem_rdata, inst_ready, redirect_valid, redirect_pc,
    output mem_en, mem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output fetch_en, mem_rdata, inst_ready, redirect_valid, redirect_pc,
    input  mem_en, mem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
// Reads four consecutive bytes from a byte-wide instruction memory, assembles
// them little-endian into a 32-bit instruction and offers it to decode over a
// valid/ready handshake. A redirect aborts any fetch in progress and restarts
// from the aligned target address.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : inst_fetch_unit_if.master (fetch enable, memory read port,
//           instruction handshake, redirect)
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_fetch_unit_if.master  bus
);

  localparam logic [ADDR_W-1:0] L_RESET_PC = {RESET_PC[ADDR_W-1:2], 2'b00};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_asm;        // lanes 0..2; lane 3 comes straight from mem_rdata
  logic [31:0]       r_inst_data;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_inst_valid;

  logic [ADDR_W-1:0] w_redirect_pc;
  logic              w_handshake;

  assign w_redirect_pc = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_handshake   = r_inst_valid & bus.inst_ready;

  // Memory request is decoded from registers only, so it moves on clock edges
  // and has no combinational path from inst_ready or redirect.
  assign bus.mem_en     = (r_state == S_FETCH);
  assign bus.mem_addr   = r_fetch_pc + {{(ADDR_W-2){1'b0}}, r_byte_cnt};
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst_data  = r_inst_data;
  assign bus.inst_pc    = r_inst_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= L_RESET_PC;
      r_byte_cnt   <= 2'd0;
      r_asm        <= 24'd0;
      r_inst_data  <= 32'd0;
      r_inst_pc    <= L_RESET_PC;
      r_inst_valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      // Redirect wins over everything; a coincident handshake still counts as
      // consumed by decode, but the target replaces the +4 increment.
      r_fetch_pc   <= w_redirect_pc;
      r_byte_cnt   <= 2'd0;
      r_inst_valid <= 1'b0;
      r_state      <= bus.fetch_en ? S_FETCH : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.fetch_en) begin
            r_state    <= S_FETCH;
            r_byte_cnt <= 2'd0;
          end
        end
        S_FETCH: begin
          case (r_byte_cnt)
            2'd0: r_asm[7:0]   <= bus.mem_rdata;
            2'd1: r_asm[15:8]  <= bus.mem_rdata;
            2'd2: r_asm[23:16] <= bus.mem_rdata;
            default: begin
              r_inst_data  <= {bus.mem_rdata, r_asm};
              r_inst_pc    <= r_fetch_pc;
              r_inst_valid <= 1'b1;
              r_state      <= S_VALID;
            end
          endcase
          r_byte_cnt <= r_byte_cnt + 2'd1;  // wraps to 0 after lane 3
        end
        S_VALID: begin
          if (w_handshake) begin
            r_fetch_pc   <= r_fetch_pc + ADDR_W'(4);
            r_inst_valid <= 1'b0;
            r_state      <= bus.fetch_en ? S_FETCH : S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_inst_valid <= 1'b0;
          r_byte_cnt   <= 2'd0;
        end
      endcase
    end
  end

endmodule
